alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SHIFT_STEP, default 1, maximum shift distance per SHIFT cycle; power of two, 1..XLEN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 opcode  input  7  RV32I/RV64I major opcode.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7_5  input  1  instruction bit 30; ADD/SUB and SRL/SRA select.
REQ-010 a  input  XLEN  operand A (rs1 or PC).
REQ-011 b  input  XLEN  operand B (rs2 or immediate).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  operation result.
REQ-015 illegal  output  1  accepted opcode/funct3 pair not decodable; qualified by out_valid.

Function
REQ-016 Request accepted on cycle where in_valid && in_ready; opcode, funct3, funct7_5, a, b captured that edge; inputs ignored otherwise.
REQ-017 FSM states: IDLE, SHIFT, DONE.
REQ-018 in_ready = (state==IDLE) || (state==DONE && out_ready); back-to-back acceptance on the DONE completion cycle.
REQ-019 Decode: LUI -> copy B; AUIPC, BRANCH, LOAD, STORE, JAL, JALR -> A+B; CSR funct3 RW -> copy A; CSR funct3 RWI -> copy B; other CSR funct3 and all other opcodes -> illegal.
REQ-020 ARI R-type funct3 000: funct7_5=0 ADD, 1 SUB; ARI I-type funct3 000: ADD regardless of funct7_5.
REQ-021 funct3 001 SLL; 101 SRL when funct7_5=0, SRA when 1 (both types); 010 SLT signed; 011 SLTU; 100 XOR; 110 OR; 111 AND.
REQ-022 SLT/SLTU result zero-extended 0/1 in XLEN bits.
REQ-023 Add/sub wrap modulo 2^XLEN; no overflow flag.
REQ-024 Shift amount = b[log2(XLEN)-1:0]; upper bits of b ignored.
REQ-025 Non-shift op or shamt 0: IDLE -> DONE on accept; out_valid next cycle (latency 1).
REQ-026 Shift with shamt>0: IDLE -> SHIFT; each SHIFT cycle shifts working register by min(SHIFT_STEP, remaining) and decrements remaining; -> DONE when remaining reaches 0; latency = 1 + ceil(shamt/SHIFT_STEP).
REQ-027 SRA fills with captured a[XLEN-1] on every step; SRL/SLL fill zero.
REQ-028 out_valid = (state==DONE); result and illegal stable while out_valid && !out_ready.
REQ-029 DONE with out_ready and no new accept -> IDLE; with accept -> DONE or SHIFT per new op.
REQ-030 Illegal op: result = 0, illegal = 1, latency 1.
REQ-031 out_ready ignored outside DONE; in_valid during SHIFT not accepted and no state change.

Reset
REQ-032 reset_n low at rising edge: state IDLE, out_valid 0, result 0, illegal 0, shift counter 0; in-flight op discarded, no output produced for it.
REQ-033 in_ready 1 on first cycle after reset_n deasserts.

Verification
REQ-034 ARI R SUB, a=5, b=7, XLEN=32 -> out_valid one cycle after accept, result 0xFFFFFFFE, illegal 0.
REQ-035 ARI I funct3 000, funct7_5=1, a=5, b=7 -> result 12 (ADDI, not SUB).
REQ-036 SRA a=0x80000000, b=31, SHIFT_STEP=4 -> latency 9, result 0xFFFFFFFF; same with SHIFT_STEP=1 -> latency 32.
REQ-037 Two back-to-back ADDs with out_ready held 1 -> second accepted on first result's DONE cycle, one result per cycle; out_ready held 0 three cycles -> result stable, in_ready 0.
REQ-038 opcode 0x7F -> out_valid with illegal 1, result 0; CSR funct3 010 -> illegal 1.
REQ-039 reset_n low during SHIFT (shamt 20, SHIFT_STEP 1) -> next cycle IDLE, out_valid 0, no stale result after release.

Source files
------------

// File: rtl/alu_iter.sv
// Iterative RV32I/RV64I integer ALU: single-cycle arithmetic/logic/CSR-move ops,
// multi-cycle shifts of up to SHIFT_STEP bit positions per cycle, valid/ready on both sides.
module alu_iter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int SAW = $clog2(XLEN);
    // One extra bit so SHIFT_STEP == XLEN is representable
    localparam int CW  = SAW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
    typedef enum logic [1:0] {SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2} shop_e;

    state_e          state_q, state_d;
    shop_e           shop_q, shop_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            ill_q, ill_d;

    logic [XLEN-1:0] dec_res_s;
    logic            dec_ill_s;
    logic            dec_shift_s;
    shop_e           dec_shop_s;
    logic [CW-1:0]   shamt_s;
    logic [CW-1:0]   step_s;
    logic [XLEN-1:0] shifted_s;
    logic            accept_s;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = work_q;
    assign illegal   = ill_q;
    assign shamt_s   = {1'b0, b[SAW-1:0]};

    // Decode the presented request; shifts report operand A as their zero-distance result
    always_comb begin
        dec_res_s   = {XLEN{1'b0}};
        dec_ill_s   = 1'b0;
        dec_shift_s = 1'b0;
        dec_shop_s  = SH_SLL;
        case (opcode)
            OPC_LUI: dec_res_s = b;
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE:
                dec_res_s = a + b;
            OPC_SYSTEM: begin
                if (funct3 == 3'b001) begin
                    dec_res_s = a;
                end else if (funct3 == 3'b101) begin
                    dec_res_s = b;
                end else begin
                    dec_ill_s = 1'b1;
                end
            end
            OPC_OP, OPC_OPIMM: begin
                case (funct3)
                    3'b000: begin
                        if ((opcode == OPC_OP) && funct7_5) begin
                            dec_res_s = a - b;
                        end else begin
                            dec_res_s = a + b;
                        end
                    end
                    3'b001: begin
                        dec_res_s   = a;
                        dec_shift_s = 1'b1;
                        dec_shop_s  = SH_SLL;
                    end
                    3'b010: dec_res_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                    3'b011: dec_res_s = {{(XLEN-1){1'b0}}, (a < b)};
                    3'b100: dec_res_s = a ^ b;
                    3'b101: begin
                        dec_res_s   = a;
                        dec_shift_s = 1'b1;
                        dec_shop_s  = funct7_5 ? SH_SRA : SH_SRL;
                    end
                    3'b110: dec_res_s = a | b;
                    3'b111: dec_res_s = a & b;
                    default: dec_ill_s = 1'b1;
                endcase
            end
            default: dec_ill_s = 1'b1;
        endcase
    end

    // One iteration of the shifter: move by min(SHIFT_STEP, remaining)
    always_comb begin
        step_s = (rem_q < STEP) ? rem_q : STEP;
        case (shop_q)
            SH_SLL:  shifted_s = work_q << step_s;
            SH_SRL:  shifted_s = work_q >> step_s;
            SH_SRA:  shifted_s = $signed(work_q) >>> step_s;
            default: shifted_s = work_q;
        endcase
    end

    // Next-state logic; an accept can only happen in IDLE or DONE
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        shop_d  = shop_q;
        ill_d   = ill_q;
        if (accept_s) begin
            ill_d  = dec_ill_s;
            rem_d  = {CW{1'b0}};
            shop_d = dec_shop_s;
            if (dec_ill_s) begin
                work_d  = {XLEN{1'b0}};
                state_d = DONE;
            end else if (dec_shift_s && (shamt_s != {CW{1'b0}})) begin
                work_d  = a;
                rem_d   = shamt_s;
                state_d = SHIFT;
            end else begin
                work_d  = dec_res_s;
                state_d = DONE;
            end
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                SHIFT: begin
                    work_d = shifted_s;
                    rem_d  = rem_q - step_s;
                    if (rem_q == step_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= {XLEN{1'b0}};
            rem_q   <= {CW{1'b0}};
            shop_q  <= SH_SLL;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            shop_q  <= shop_d;
            ill_q   <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, random ops against a
// behavioural model, and hand sequences for handshake, stall and reset corners.
module tb_alu_iter;

    localparam int STEP = 4;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, funct7_5, out_valid, out_ready, illegal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] a, b, result;

    logic        reset_n1, in_valid1, in_ready1, funct7_5_1, out_valid1, out_ready1, illegal1;
    logic [6:0]  opcode1;
    logic [2:0]  funct3_1;
    logic [31:0] a1, b1, result1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_iter #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
    );

    alu_iter #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .reset_n(reset_n1), .in_valid(in_valid1), .in_ready(in_ready1),
        .opcode(opcode1), .funct3(funct3_1), .funct7_5(funct7_5_1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1), .illegal(illegal1)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] res, input logic ill, input int lat);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.a = va; v.b = vb;
        v.res = res; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    // Reference: instruction semantics straight from the ISA rules
    function automatic vec_t model(input vec_t v);
        vec_t m;
        int   sh;
        logic isop;
        m = v;
        sh = int'(v.b[4:0]);
        isop = (v.op == 7'h33) || (v.op == 7'h13);
        m.ill = 1'b0;
        m.res = 32'd0;
        m.lat = 1;
        if (v.op == 7'h37) m.res = v.b;
        else if (v.op inside {7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23}) m.res = v.a + v.b;
        else if (v.op == 7'h73 && v.f3 == 3'd1) m.res = v.a;
        else if (v.op == 7'h73 && v.f3 == 3'd5) m.res = v.b;
        else if (isop) begin
            case (v.f3)
                3'd0: m.res = (v.op == 7'h33 && v.f7) ? v.a - v.b : v.a + v.b;
                3'd1: m.res = v.a << sh;
                3'd2: m.res = ($signed(v.a) < $signed(v.b)) ? 32'd1 : 32'd0;
                3'd3: m.res = (v.a < v.b) ? 32'd1 : 32'd0;
                3'd4: m.res = v.a ^ v.b;
                3'd5: m.res = v.f7 ? 32'($signed(v.a) >>> sh) : v.a >> sh;
                3'd6: m.res = v.a | v.b;
                default: m.res = v.a & v.b;
            endcase
            if ((v.f3 == 3'd1 || v.f3 == 3'd5) && sh > 0) m.lat = 1 + (sh + STEP - 1) / STEP;
        end else m.ill = 1'b1;
        return m;
    endfunction

    task automatic run_op(input vec_t v, output logic [31:0] r, output logic il, output int lat);
        @(negedge clk);
        opcode = v.op; funct3 = v.f3; funct7_5 = v.f7; a = v.a; b = v.b;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        il = illegal;
    endtask

    vec_t        tbl[17];
    vec_t        v, m;
    logic [31:0] r;
    logic        il;
    int          lat;
    int          seen;
    logic [6:0]  ops[11];

    initial begin
        tbl[0]  = mk(7'h33, 3'd0, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1);
        tbl[1]  = mk(7'h13, 3'd0, 1'b1, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        tbl[2]  = mk(7'h33, 3'd5, 1'b1, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 9);
        tbl[3]  = mk(7'h7F, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1);
        tbl[4]  = mk(7'h73, 3'd2, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1);
        tbl[5]  = mk(7'h37, 3'd0, 1'b0, 32'd1, 32'h12345000, 32'h12345000, 1'b0, 1);
        tbl[6]  = mk(7'h73, 3'd1, 1'b0, 32'hDEAD, 32'hBEEF, 32'hDEAD, 1'b0, 1);
        tbl[7]  = mk(7'h73, 3'd5, 1'b0, 32'hDEAD, 32'hBEEF, 32'hBEEF, 1'b0, 1);
        tbl[8]  = mk(7'h33, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
        tbl[9]  = mk(7'h33, 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
        tbl[10] = mk(7'h33, 3'd5, 1'b0, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 2);
        tbl[11] = mk(7'h13, 3'd1, 1'b0, 32'h1234, 32'h20, 32'h1234, 1'b0, 1);
        tbl[12] = mk(7'h33, 3'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
        tbl[13] = mk(7'h33, 3'd4, 1'b0, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1);
        tbl[14] = mk(7'h67, 3'd0, 1'b0, 32'h100, 32'd4, 32'h104, 1'b0, 1);
        tbl[15] = mk(7'h13, 3'd1, 1'b0, 32'd1, 32'd5, 32'd32, 1'b0, 3);
        tbl[16] = mk(7'h33, 3'd5, 1'b1, 32'h80000000, 32'd3, 32'hF0000000, 1'b0, 2);
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; a = 32'd0; b = 32'd0;
        reset_n1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
        opcode1 = 7'd0; funct3_1 = 3'd0; funct7_5_1 = 1'b0; a1 = 32'd0; b1 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        reset_n = 1'b1; reset_n1 = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i], r, il, lat);
            chk($sformatf("tbl%0d_res", i), {32'd0, r}, {32'd0, tbl[i].res});
            chk($sformatf("tbl%0d_ill", i), {63'd0, il}, {63'd0, tbl[i].ill});
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
        end

        for (int i = 0; i < 150; i++) begin
            v.op = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) v.op = 7'($urandom);
            v.f3 = 3'($urandom); v.f7 = 1'($urandom);
            v.a = $urandom; v.b = $urandom;
            m = model(v);
            run_op(v, r, il, lat);
            chk($sformatf("rnd%0d_res", i), {32'd0, r}, {32'd0, m.res});
            chk($sformatf("rnd%0d_ill", i), {63'd0, il}, {63'd0, m.ill});
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(m.lat));
        end

        // Back-to-back ADDs, then a three-cycle output stall
        @(negedge clk);
        opcode = 7'h33; funct3 = 3'd0; funct7_5 = 1'b0; a = 32'd1; b = 32'd2;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_first_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_first_res", {32'd0, result}, 64'd3);
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        a = 32'd3; b = 32'd4;
        @(negedge clk);
        chk("b2b_second_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_second_res", {32'd0, result}, 64'd7);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_res", {32'd0, result}, 64'd7);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_idle", {63'd0, out_valid}, 64'd0);

        // Request held during SHIFT must wait, then go in on the DONE cycle
        opcode = 7'h33; funct3 = 3'd1; funct7_5 = 1'b0; a = 32'd3; b = 32'd8;
        in_valid = 1'b1;
        @(negedge clk);
        funct3 = 3'd0; a = 32'd10; b = 32'd20;
        chk("shift_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("shift_busy_valid", {63'd0, out_valid}, 64'd0);
        chk("shift_busy_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("shift_done_valid", {63'd0, out_valid}, 64'd1);
        chk("shift_done_res", {32'd0, result}, 64'd768);
        @(negedge clk);
        chk("after_shift_add", {32'd0, result}, 64'd30);
        in_valid = 1'b0;

        // SHIFT_STEP=1 worst-case SRA latency
        @(negedge clk);
        opcode1 = 7'h33; funct3_1 = 3'd5; funct7_5_1 = 1'b1; a1 = 32'h80000000; b1 = 32'd31;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("s1_sra_lat", 64'(lat), 64'd32);
        chk("s1_sra_res", {32'd0, result1}, 64'hFFFFFFFF);

        // Reset in the middle of a 20-step shift
        @(negedge clk);
        funct3_1 = 3'd1; funct7_5_1 = 1'b0; a1 = 32'd1; b1 = 32'd20; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n1 = 1'b0;
        @(negedge clk);
        chk("rst_shift_valid", {63'd0, out_valid1}, 64'd0);
        chk("rst_shift_result", {32'd0, result1}, 64'd0);
        chk("rst_shift_ready", {63'd0, in_ready1}, 64'd1);
        reset_n1 = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid1) seen++;
        end
        chk("rst_shift_no_stale", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
